// File: rtl/im_loader_pkg.sv
// ----------------------------------------------------------------------------
// im_loader_pkg
//   Shared definitions for the instruction-memory loader.
//   - CPU run-state encodings driven on curr_state. The fetch and control
//     units decode the same values, so they must not change here alone.
//   - Loader FSM state encoding.
// ----------------------------------------------------------------------------
package im_loader_pkg;

    // CPU run state carried on curr_state
    localparam logic [1:0] CPU_IDLE = 2'b00;
    localparam logic [1:0] CPU_RUN  = 2'b01;

    // Loader FSM states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_RUN   = 3'd4
    } ld_state_t;

endpackage

// File: rtl/im_word_packer.sv
// ----------------------------------------------------------------------------
// im_word_packer
//   Packs host bytes into 32-bit words, MSB first.
//   The first three bytes of a word are held in a 24-bit shift register; the
//   fourth byte is never stored here. word_o is the word as it stands once
//   the byte currently on byte_i is shifted in, so the consumer can register
//   the complete word on the same edge that accepts the 4th byte.
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   shift_en_i  in   shift byte_i in on this edge
//   clear_i     in   drop any partial word and restart at byte 0
//   byte_i      in   incoming byte
//   word_o      out  {held bytes, byte_i}
//   word_full_o out  this shift completes a word
// ----------------------------------------------------------------------------
module im_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        shift_en_i,
    input  logic        clear_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    logic [23:0] hold_q, hold_d;
    logic [1:0]  cnt_q,  cnt_d;

    always_comb begin
        hold_d = hold_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            hold_d = '0;
            cnt_d  = '0;
        end else if (shift_en_i) begin
            hold_d = {hold_q[15:0], byte_i};
            // 2-bit counter wraps 3 -> 0 as the word completes
            cnt_d  = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
            cnt_q  <= '0;
        end else begin
            hold_q <= hold_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o      = {hold_q, byte_i};
    assign word_full_o = shift_en_i && !clear_i && (cnt_q == 2'd3);

endmodule

// File: rtl/im_loader.sv
// ----------------------------------------------------------------------------
// im_loader
//   Host-facing writer for the instruction memory. Receives a length byte L
//   followed by 4*(L+1) data bytes over a valid/ready byte link, packs them
//   MSB first and writes one word per 5 cycles at word addresses 0..L.
//   Holds curr_state at IDLE (fetch PC parked at 0) while loading and switches
//   to RUN once the last word is written. A stalled host link aborts the load
//   after TIMEOUT_CYC idle cycles and raises the sticky load_err.
//
// Ports (all outputs registered):
//   clk, rst_n    clock, asynchronous active-low reset
//   load_start    pulse: begin a new load (honoured in IDLE and RUN only)
//   rx_data/rx_valid/rx_ready   host byte handshake
//   im_wea/im_addr/im_din       IM write port, one-cycle pulse per word
//   curr_state    CPU run state (CPU_IDLE / CPU_RUN)
//   load_done     pulse on the first RUN cycle after a complete load
//   load_err      sticky timeout flag, cleared by load_start
//   words_loaded  words written by the current or last load (0..256)
// ----------------------------------------------------------------------------
module im_loader
    import im_loader_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_wea,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_din,
    output logic [1:0]        curr_state,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC - 1);

    ld_state_t         state_q, state_d;
    logic [ADDR_W-1:0] idx_q,   idx_d;    // word index of the next write
    logic [ADDR_W-1:0] len_q,   len_d;    // L: index of the final word
    logic [TW-1:0]     tmo_q,   tmo_d;
    logic              rx_ready_q, rx_ready_d;
    logic              wea_q,   wea_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [31:0]       din_q,   din_d;
    logic [1:0]        curr_q,  curr_d;
    logic              done_q,  done_d;
    logic              err_q,   err_d;
    logic [ADDR_W:0]   words_q, words_d;

    logic        accept;
    logic        pk_shift, pk_clear, pk_full;
    logic [31:0] pk_word;

    assign accept = rx_valid && rx_ready_q;

    im_word_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .shift_en_i  (pk_shift),
        .clear_i     (pk_clear),
        .byte_i      (rx_data),
        .word_o      (pk_word),
        .word_full_o (pk_full)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        tmo_d    = tmo_q;
        addr_d   = addr_q;
        din_d    = din_q;
        err_d    = err_q;
        words_d  = words_q;
        wea_d    = 1'b0;
        done_d   = 1'b0;
        pk_shift = 1'b0;
        pk_clear = 1'b0;

        case (state_q)
            S_IDLE, S_RUN: begin
                if (load_start) begin
                    state_d  = S_LEN;
                    idx_d    = '0;
                    tmo_d    = '0;
                    err_d    = 1'b0;
                    words_d  = '0;
                    pk_clear = 1'b1;
                end
            end
            S_LEN: begin
                if (accept) begin
                    len_d   = rx_data;
                    tmo_d   = '0;
                    state_d = S_DATA;
                end else if (tmo_q == TMO_MAX) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_DATA: begin
                if (accept) begin
                    pk_shift = 1'b1;
                    tmo_d    = '0;
                    if (pk_full) begin
                        // Register the write now so im_wea lands in S_WRITE
                        state_d = S_WRITE;
                        wea_d   = 1'b1;
                        addr_d  = idx_q;
                        din_d   = pk_word;
                    end
                end else if (tmo_q == TMO_MAX) begin
                    // Abort: the partial word is dropped, written words stay
                    state_d  = S_IDLE;
                    err_d    = 1'b1;
                    tmo_d    = '0;
                    pk_clear = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WRITE: begin
                idx_d   = idx_q + ADDR_W'(1);
                words_d = words_q + (ADDR_W+1)'(1);
                if (idx_q == len_q) begin
                    state_d = S_RUN;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_DATA;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered outputs follow the state being entered
        rx_ready_d = (state_d == S_LEN) || (state_d == S_DATA);
        curr_d     = (state_d == S_RUN) ? CPU_RUN : CPU_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            tmo_q      <= '0;
            rx_ready_q <= 1'b0;
            wea_q      <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            curr_q     <= CPU_IDLE;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            words_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            tmo_q      <= tmo_d;
            rx_ready_q <= rx_ready_d;
            wea_q      <= wea_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            curr_q     <= curr_d;
            done_q     <= done_d;
            err_q      <= err_d;
            words_q    <= words_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign im_wea       = wea_q;
    assign im_addr      = addr_q;
    assign im_din       = din_q;
    assign curr_state   = curr_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_im_loader.sv
// ----------------------------------------------------------------------------
// tb_im_loader
//   Scoreboard bench for im_loader. Stimulus pushes expected IM writes and
//   load completions into queues; a monitor pops and compares on every
//   im_wea / load_done it observes.
// ----------------------------------------------------------------------------
module tb_im_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        im_wea;
    logic [7:0]  im_addr;
    logic [31:0] im_din;
    logic [1:0]  curr_state;
    logic        load_done;
    logic        load_err;
    logic [8:0]  words_loaded;

    always #5 clk = ~clk;

    im_loader #(.ADDR_W(8), .TIMEOUT_CYC(1024)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start   (load_start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .im_wea       (im_wea),
        .im_addr      (im_addr),
        .im_din       (im_din),
        .curr_state   (curr_state),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    int checks = 0;
    int errors = 0;

    logic [39:0] exp_wr[$];    // {addr, din}
    logic [8:0]  exp_done[$];  // words_loaded at completion
    logic [31:0] prog[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every write / completion the DUT presents must match the queue
    initial begin
        logic [39:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (im_wea) begin
                    if (exp_wr.size() == 0) begin
                        chk("unexpected_write", {im_addr, im_din}, 40'h0);
                    end else begin
                        e = exp_wr.pop_front();
                        chk("wr_addr", im_addr, e[39:32]);
                        chk("wr_din", im_din, e[31:0]);
                        chk("wr_state_idle", curr_state, 2'b00);
                    end
                end
                if (load_done) begin
                    if (exp_done.size() == 0) begin
                        chk("unexpected_done", words_loaded, 9'h0);
                    end else begin
                        chk("done_words", words_loaded, exp_done.pop_front());
                        chk("done_state_run", curr_state, 2'b01);
                    end
                end
            end
        end
    end

    // Absolute time limit
    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Called and returns at a negedge; byte is accepted at the posedge between
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) chk("rx_ready_wait", 0, 1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic load(input logic [7:0] len, input int maxgap);
        logic [31:0] w;
        pulse_start();
        chk("idle_after_start", curr_state, 2'b00);
        chk("err_cleared", load_err, 1'b0);
        exp_done.push_back(9'(len) + 9'd1);
        send_byte(len, $urandom_range(0, maxgap));
        for (int i = 0; i <= int'(len); i++) begin
            w = prog[i];
            exp_wr.push_back({8'(i), w});
            for (int k = 3; k >= 0; k--)
                send_byte(w[k*8 +: 8], $urandom_range(0, maxgap));
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [7:0] ib;
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_rx_ready", rx_ready, 1'b0);
        chk("rst_wea", im_wea, 1'b0);
        chk("rst_addr", im_addr, 8'h0);
        chk("rst_din", im_din, 32'h0);
        chk("rst_state", curr_state, 2'b00);
        chk("rst_done", load_done, 1'b0);
        chk("rst_err", load_err, 1'b0);
        chk("rst_words", words_loaded, 9'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_ready", rx_ready, 1'b0);

        // Two-word program, back-to-back bytes
        prog = '{32'hDEADBEEF, 32'h0000002A};
        load(8'h01, 0);
        chk("t1_run", curr_state, 2'b01);
        chk("t1_words", words_loaded, 9'd2);

        // Same program with random gaps, started from RUN
        load(8'h01, 5);
        chk("t2_run", curr_state, 2'b01);
        chk("t2_words", words_loaded, 9'd2);

        // Timeout after a partial word
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        repeat (1000) @(negedge clk);
        chk("t3_err_early", load_err, 1'b0);
        repeat (30) @(negedge clk);
        chk("t3_err", load_err, 1'b1);
        chk("t3_state", curr_state, 2'b00);
        chk("t3_words", words_loaded, 9'd0);
        chk("t3_ready", rx_ready, 1'b0);
        pulse_start();
        chk("t3_err_clr", load_err, 1'b0);
        // Finish this load as one word; load_start mid-load is ignored
        exp_done.push_back(9'd1);
        exp_wr.push_back({8'h00, 32'h12345678});
        send_byte(8'h00, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        pulse_start();
        send_byte(8'h56, 0);
        pulse_start();
        send_byte(8'h78, 0);
        repeat (3) @(negedge clk);
        chk("t3_run", curr_state, 2'b01);
        chk("t3_words1", words_loaded, 9'd1);

        // Full 256-word image
        prog.delete();
        for (int i = 0; i < 256; i++) begin
            ib = 8'(i);
            prog.push_back({ib, ~ib, 8'hA5, ib ^ 8'h3C});
        end
        load(8'hFF, 0);
        chk("t4_run", curr_state, 2'b01);
        chk("t4_words", words_loaded, 9'd256);

        // Reload one word from RUN, overwriting address 0
        prog.delete();
        prog.push_back(32'hCAFEF00D);
        load(8'h00, 2);
        chk("t5_run", curr_state, 2'b01);
        chk("t5_words", words_loaded, 9'd1);

        // Reset during S_WRITE of the second word
        pulse_start();
        send_byte(8'h01, 0);
        exp_wr.push_back({8'h00, 32'hA1B2C3D4});
        send_byte(8'hA1, 0);
        send_byte(8'hB2, 0);
        send_byte(8'hC3, 0);
        send_byte(8'hD4, 0);
        send_byte(8'h41, 0);
        send_byte(8'h42, 0);
        send_byte(8'h43, 0);
        rx_valid = 1'b1;
        rx_data  = 8'h44;
        begin
            int n = 0;
            while (!rx_ready && n < 10) begin
                @(negedge clk);
                n++;
            end
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        chk("t6_wea_before", im_wea, 1'b1);
        chk("t6_addr_before", im_addr, 8'h01);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_wea_rst", im_wea, 1'b0);
        chk("t6_state_rst", curr_state, 2'b00);
        chk("t6_addr_rst", im_addr, 8'h0);
        chk("t6_din_rst", im_din, 32'h0);
        chk("t6_words_rst", words_loaded, 9'h0);
        chk("t6_ready_rst", rx_ready, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (20) @(negedge clk);
        chk("t6_no_ready", rx_ready, 1'b0);
        chk("t6_idle", curr_state, 2'b00);
        chk("t6_words", words_loaded, 9'h0);
        rx_valid = 1'b0;

        chk("pending_writes", exp_wr.size(), 0);
        chk("pending_done", exp_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Writer side of the instruction memory. The fetch unit only ever reads the IM; this block is the host-facing loader that fills it.
- Accepts a byte stream from a host link (UART RX / debug port) over a valid/ready handshake and packs bytes into 32-bit words, MSB first.
- Writes each word into the IM write port at consecutive word addresses from 0.
- Drives the shared curr_state: held IDLE while loading, which keeps the fetch PC at 0; switches to RUN when the program is complete.

Parameters:
- ADDR_W, 8, IM word-address width. Fixed at 8 because the length header is one byte; depth is 256 words.
- TIMEOUT_CYC, 1024, idle cycles allowed between accepted bytes during a load before it aborts.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- load_start  in  1  single-cycle pulse requesting a new program load
- rx_data  in  8  host byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept a byte
- im_wea  out  1  IM write enable, one-cycle pulse per word
- im_addr  out  ADDR_W  IM word address
- im_din  out  32  IM write data
- curr_state  out  2  CPU run state: 2'b00 IDLE, 2'b01 RUN
- load_done  out  1  one-cycle pulse when the final word has been written
- load_err  out  1  sticky timeout flag; cleared by the next load_start
- words_loaded  out  ADDR_W+1  count of words written in the current or last load

Behaviour:
- Reset, asynchronous on rst_n low:
  - FSM goes to S_IDLE.
  - rx_ready, im_wea, im_addr, im_din, load_done, load_err and words_loaded all reset to 0; curr_state resets to 2'b00.
  - IM contents are not touched.
- All outputs are registered.
- Handshake: a byte is accepted on a rising clk edge with rx_valid && rx_ready. rx_ready is 1 only in S_LEN and S_DATA. Bytes presented in any other state stay pending and are not consumed.
- Stream format: one length byte L, meaning N = L+1 words (1..256), followed by 4*N data bytes. The first data byte is im_din[31:24].
- FSM:
  - S_IDLE: curr_state=IDLE. load_start -> S_LEN, clear load_err, words_loaded and word index.
  - S_LEN: accept L -> S_DATA, latch N.
  - S_DATA: each accepted byte does word <= {word[23:0], rx_data} and byte_cnt++. The 4th byte -> S_WRITE, byte_cnt <= 0.
  - S_WRITE: one cycle with im_wea=1, im_addr=word index, im_din=assembled word, rx_ready=0. Then word index++ and words_loaded++.
    - If the written index is N-1 -> S_RUN, with load_done=1 on the same cycle curr_state first becomes RUN.
    - Otherwise -> S_DATA.
  - S_RUN: curr_state=RUN. load_start -> S_LEN, and curr_state returns to IDLE on the next cycle.
- Latency: the im_wea pulse occurs in the cycle after the edge that accepted the 4th byte of a word. Sustained throughput is 1 word per 5 cycles.
- Timeout:
  - In S_LEN and S_DATA a counter increments on every cycle with no accepted byte and clears on each accepted byte.
  - When it reaches TIMEOUT_CYC-1 the FSM goes to S_IDLE with load_err=1.
  - A partially assembled word is discarded (never written). Words already written remain, and curr_state stays IDLE.
- load_start is ignored in S_LEN, S_DATA and S_WRITE.
- L=0xFF loads 256 words: im_addr wraps no further, the last write is to 0xFF, then the FSM goes to S_RUN. words_loaded=256, which is why it is ADDR_W+1 bits wide.
- Reset mid-load: returns to S_IDLE with curr_state IDLE. Any IM write in that cycle is cancelled asynchronously with im_wea.

Decomposition:
- Shared header: IDLE/RUN encodings (2'b00/2'b01), shared with the fetch and control units, plus the loader state encodings.
- One sub-module, im_word_packer: 4-byte shift register and byte counter, with inputs shift_en and clear and outputs word and word_full. The loader FSM and timeout logic stay in im_loader.

Test Plan:
- Reset then load_start, stream 0x01, DE AD BE EF, 00 00 00 2A back-to-back -> im_wea pulses at addr 0 din 0xDEADBEEF and addr 1 din 0x0000002A; load_done 1 cycle; curr_state 2'b01; words_loaded=2.
- Same stream with rx_valid toggled randomly (gaps < TIMEOUT_CYC) -> identical IM writes; no byte accepted while rx_ready=0.
- load_start, L=0x00, 3 bytes, then silence for TIMEOUT_CYC cycles -> no im_wea; load_err=1; curr_state stays 2'b00; next load_start clears load_err.
- L=0xFF with 1024 bytes -> 256 writes, addresses 0x00..0xFF in order; words_loaded=256; RUN only after the write to 0xFF.
- In RUN, pulse load_start -> curr_state=2'b00 the next cycle; reload 1 word overwrites addr 0; load_start pulses mid-load are ignored.
- Assert rst_n low during S_WRITE -> im_wea drops immediately; all outputs at reset values; no further writes until load_start.
